// File: rtl/fpu_pkg.sv
// fpu_pkg: shared op codes, sequencer states and constants for the FPU sequencer
package fpu_pkg;

    typedef enum logic [3:0] {
        OP_FADD     = 4'b0000,
        OP_FSUB     = 4'b0001,
        OP_FMUL     = 4'b0010,
        OP_FDIV     = 4'b0011,
        OP_FCVT_S_W = 4'b0100,
        OP_FCVT_W_S = 4'b0101,
        OP_FEQ      = 4'b0110,
        OP_FLT      = 4'b0111,
        OP_FLE      = 4'b1000
    } fpu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_A,
        S_SEND_B,
        S_WAIT_Z,
        S_ACK_Z,
        S_RESP
    } state_e;

    localparam logic [31:0] FPU_CANON_NAN = 32'h7FC00000;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_FLE;
    endfunction

    function automatic logic op_unary(input logic [3:0] op);
        return op == OP_FCVT_S_W || op == OP_FCVT_W_S;
    endfunction

endpackage

// File: rtl/fpu_seq_timer.sv
// fpu_seq_timer: per-transaction watchdog, flags the last allowed counted cycle
module fpu_seq_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [W-1:0] r_cnt;

    // count cycles spent waiting on the FPU, restart on every accepted request
    always_ff @(posedge clk) begin
        if (!reset_n || i_clear)
            r_cnt <= '0;
        else if (i_count)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = i_count && (r_cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fpu_sequencer.sv
// fpu_sequencer: steps one core FPU request through the strobe/ack FPU handshake (watchdog: FPU_SEQ_TIMEOUT_EN)
module fpu_sequencer
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [3:0]  fpu_op,
    output logic [31:0] fpu_in1,
    output logic [31:0] fpu_in2,
    output logic        fpu_in1_stb,
    output logic        fpu_in2_stb,
    input  logic        fpu_in1_ack,
    input  logic        fpu_in2_ack,
    input  logic [31:0] fpu_out,
    input  logic        fpu_out_stb,
    output logic        fpu_out_ack,
    output logic        busy
);

    state_e      r_state, w_next;
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b, r_data;
    logic        r_err;
    logic        w_accept, w_counting, w_expired;

    assign w_accept   = (r_state == S_IDLE) && req_valid;
    assign w_counting = (r_state == S_SEND_A) || (r_state == S_SEND_B) || (r_state == S_WAIT_Z);

`ifdef FPU_SEQ_TIMEOUT_EN
    fpu_seq_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_accept),
        .i_count   (w_counting),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // next state and state-decoded handshake outputs; a watchdog expiry overrides any progress
    always_comb begin
        w_next      = r_state;
        req_ready   = r_state == S_IDLE;
        busy        = r_state != S_IDLE;
        fpu_in1_stb = r_state == S_SEND_A;
        fpu_in2_stb = r_state == S_SEND_B;
        fpu_out_ack = r_state == S_ACK_Z;
        resp_valid  = r_state == S_RESP;
        case (r_state)
            S_IDLE:   if (req_valid) w_next = op_legal(req_op) ? S_SEND_A : S_RESP;
            S_SEND_A: if (fpu_in1_ack) w_next = S_SEND_B;
            S_SEND_B: if (fpu_in2_ack) w_next = S_WAIT_Z;
            S_WAIT_Z: if (fpu_out_stb) w_next = S_ACK_Z;
            S_ACK_Z:  w_next = S_RESP;
            S_RESP:   if (resp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_expired)
            w_next = S_RESP;
    end

    // operand latch and result capture; unary ops ship a zero second operand
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_op   <= req_op;
            r_a    <= req_a;
            r_b    <= op_unary(req_op) ? 32'h0 : req_b;
            r_data <= '0;
            r_err  <= !op_legal(req_op);
        end else if (w_expired) begin
            r_data <= FPU_CANON_NAN;
            r_err  <= 1'b1;
        end else if (r_state == S_WAIT_Z && fpu_out_stb) begin
            r_data <= fpu_out;
        end
    end

    assign fpu_op    = r_op;
    assign fpu_in1   = r_a;
    assign fpu_in2   = r_b;
    assign resp_data = r_data;
    assign resp_err  = r_err;

endmodule
